// File: rtl/scan_decoder_pkg.sv
// Shared mode encodings and default parameter values for the scan_decoder block.
package scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int DEF_SEL_W = 4;
    localparam int DEF_OUT_W = 10;
    localparam int DEF_DWELL = 1;

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational SEL_W-to-OUT_W one-hot decoder; codes >= OUT_W give all-zero and in_range=0.
module onehot_dec #(
    parameter int SEL_W = 4,
    parameter int OUT_W = 10
) (
    input  logic [SEL_W-1:0] code,
    output logic [OUT_W-1:0] onehot,
    output logic             in_range
);

    localparam logic [SEL_W:0] LIMIT = (SEL_W+1)'(OUT_W);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        onehot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            onehot[i] = (code == SEL_W'(i));
        end
    end

    assign in_range = ({1'b0, code} < LIMIT);

endmodule

// File: rtl/scan_decoder.sv
// One-hot decoder with direct decode and optional auto-scan; scan mode is built only when
// the macro SCAN_DECODER_SCAN_EN is defined.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int DWELL = DEF_DWELL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             err,
    output logic             wrap
);

    logic [SEL_W-1:0] dec_code;
    logic [OUT_W-1:0] dec_onehot;
    logic             dec_in_range;

    onehot_dec #(.SEL_W(SEL_W), .OUT_W(OUT_W)) u_dec (
        .code    (dec_code),
        .onehot  (dec_onehot),
        .in_range(dec_in_range)
    );

`ifdef SCAN_DECODER_SCAN_EN
    localparam int              CNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST  = SEL_W'(OUT_W - 1);

    logic [SEL_W-1:0] idx, idx_next;
    logic [CNT_W-1:0] dcnt;
    logic             in_scan;   // scan was active on the last enabled cycle
    logic             blank;     // last cycle had en=0
    logic             scan_sel, scan_entry, scan_resume, scan_step;

    assign scan_sel    = (mode == MODE_SCAN);
    assign in_ready    = en && !scan_sel;
    assign scan_entry  = scan_sel && !in_scan;
    assign scan_resume = scan_sel && in_scan && blank;
    assign scan_step   = scan_sel && in_scan && !blank && (dcnt == DCNT_LAST);
    assign idx_next    = (idx == IDX_LAST) ? '0 : idx + SEL_W'(1);

    // The decoder is shared: scan paths steer it to the index that out is about to show.
    always_comb begin
        dec_code = sel;
        if (scan_entry)       dec_code = '0;
        else if (scan_resume) dec_code = idx;
        else if (scan_sel)    dec_code = idx_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            wrap      <= 1'b0;
            idx       <= '0;
            dcnt      <= '0;
            in_scan   <= 1'b0;
            blank     <= 1'b0;
        end else if (!en) begin
            out       <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            blank     <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            blank     <= 1'b0;
            if (scan_sel) begin
                in_scan <= 1'b1;
                if (scan_entry) begin
                    idx       <= '0;
                    dcnt      <= '0;
                    out       <= dec_onehot;
                    err       <= 1'b0;
                    out_valid <= 1'b1;
                end else if (scan_resume) begin
                    out       <= dec_onehot;
                    out_valid <= 1'b1;
                end else if (scan_step) begin
                    dcnt      <= '0;
                    idx       <= idx_next;
                    out       <= dec_onehot;
                    out_valid <= 1'b1;
                    wrap      <= (idx == IDX_LAST);
                end else begin
                    dcnt <= dcnt + CNT_W'(1);
                end
            end else begin
                in_scan <= 1'b0;
                idx     <= '0;
                dcnt    <= '0;
                if (in_valid) begin
                    out       <= dec_onehot;
                    err       <= !dec_in_range;
                    out_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = mode ^ (DWELL > 0);
    assign in_ready   = en;
    assign dec_code   = sel;
    assign wrap       = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else if (!en) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                out       <= dec_onehot;
                err       <= !dec_in_range;
                out_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder (SEL_W=4, OUT_W=10, DWELL=2); scan checks run when
// SCAN_DECODER_SCAN_EN is defined.
module tb_scan_decoder;

    localparam int SEL_W = 4;
    localparam int OUT_W = 10;
    localparam int DWELL = 2;

    typedef struct packed {
        logic [OUT_W-1:0] out;
        logic             err;
        logic             wrap;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n, en, mode, in_valid, in_ready;
    logic [SEL_W-1:0] sel;
    logic [OUT_W-1:0] out;
    logic             out_valid, err, wrap;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    scan_decoder #(.SEL_W(SEL_W), .OUT_W(OUT_W), .DWELL(DWELL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .out      (out),
        .out_valid(out_valid),
        .err      (err),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [OUT_W-1:0] o, input logic e, input logic w);
        sb.push_back('{out: o, err: e, wrap: w});
    endtask

    // Issue one transfer; out_valid must be up right after the capturing edge.
    task automatic xfer(input logic [SEL_W-1:0] s, input logic [OUT_W-1:0] o, input logic e);
        sel      = s;
        in_valid = 1'b1;
        push(o, e, 1'b0);
        cyc();
        check("xfer_out_valid", out_valid, 1'b1);
    endtask

    task automatic idle_hold(input logic [OUT_W-1:0] o);
        in_valid = 1'b0;
        cyc();
        check("hold_out", out, o);
        check("hold_no_valid", out_valid, 1'b0);
    endtask

    // Monitor: pops one expectation per out_valid pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("sb_out", out, e.out);
                    check("sb_err", err, e.err);
                    check("sb_wrap", wrap, e.wrap);
                end
            end else begin
                check("wrap_without_valid", wrap, 1'b0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0; sel = '0;
        #1;
        check("rst_out", out, '0);
        check("rst_err", err, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_wrap", wrap, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc();
        check("disabled_in_ready", in_ready, 1'b0);
        en = 1'b1;
        #1;
        check("direct_in_ready", in_ready, 1'b1);

        // Direct decode, single and back-to-back transfers, out-of-range codes.
        xfer(4'd3, 10'b0000001000, 1'b0);
        idle_hold(10'b0000001000);
        xfer(4'd12, 10'b0000000000, 1'b1);
        idle_hold(10'b0000000000);
        check("err_held", err, 1'b1);
        xfer(4'd9, 10'b1000000000, 1'b0);
        idle_hold(10'b1000000000);
        xfer(4'd0, 10'b0000000001, 1'b0);
        xfer(4'd9, 10'b1000000000, 1'b0);
        xfer(4'd5, 10'b0000100000, 1'b0);
        idle_hold(10'b0000100000);
        xfer(4'd10, 10'b0000000000, 1'b1);
        xfer(4'd15, 10'b0000000000, 1'b1);
        idle_hold(10'b0000000000);

`ifdef SCAN_DECODER_SCAN_EN
        // Mode switch with in_valid in the same cycle: not accepted, scan entry clears err.
        mode = 1'b1; sel = 4'd2; in_valid = 1'b1;
        #1;
        check("scan_in_ready", in_ready, 1'b0);
        push(10'b0000000001, 1'b0, 1'b0);
        push(10'b0000000010, 1'b0, 1'b0);
        push(10'b0000000100, 1'b0, 1'b0);
        push(10'b0000001000, 1'b0, 1'b0);
        push(10'b0000010000, 1'b0, 1'b0);
        push(10'b0000100000, 1'b0, 1'b0);
        push(10'b0001000000, 1'b0, 1'b0);
        push(10'b0010000000, 1'b0, 1'b0);
        push(10'b0100000000, 1'b0, 1'b0);
        push(10'b1000000000, 1'b0, 1'b0);
        push(10'b0000000001, 1'b0, 1'b1);
        cyc();
        in_valid = 1'b0;
        check("entry_out", out, 10'b0000000001);
        cyc();
        check("dwell_hold", out, 10'b0000000001);
        check("dwell_no_valid", out_valid, 1'b0);
        cyc(19);
        check("wrap_out", out, 10'b0000000001);
        check("wrap_pulse", wrap, 1'b1);
        push(10'b0000000010, 1'b0, 1'b0);
        push(10'b0000000100, 1'b0, 1'b0);
        push(10'b0000001000, 1'b0, 1'b0);
        push(10'b0000010000, 1'b0, 1'b0);
        cyc(8);
        check("scan_idx4", out, 10'b0000010000);

        // Blank for three cycles, then resume at the frozen index.
        en = 1'b0;
        #1;
        check("blank_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("blank_out", out, '0);
        end
        en = 1'b1;
        push(10'b0000010000, 1'b0, 1'b0);
        push(10'b0000100000, 1'b0, 1'b0);
        cyc();
        check("resume_out", out, 10'b0000010000);
        cyc(2);
        check("resume_next", out, 10'b0000100000);
        cyc();

        // Asynchronous reset mid-scan, then re-entry with mode=1.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", out, '0);
        check("async_rst_valid", out_valid, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        push(10'b0000000001, 1'b0, 1'b0);
        cyc();
        check("reentry_valid", out_valid, 1'b1);
        check("reentry_out", out, 10'b0000000001);

        // Scan to direct: out holds, no pulse.
        mode = 1'b0;
        cyc();
        check("to_direct_hold", out, 10'b0000000001);
        check("to_direct_no_valid", out_valid, 1'b0);
`else
        // Mode is ignored: a transfer is still accepted with mode=1.
        mode = 1'b1;
        #1;
        check("mode_ignored_ready", in_ready, 1'b1);
        xfer(4'd2, 10'b0000000100, 1'b0);
        idle_hold(10'b0000000100);
        check("wrap_tied", wrap, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", out, '0);
        cyc(2);
        rst_n = 1'b1;
        mode = 1'b0;
        cyc();
`endif

        // en returning in direct mode: out stays 0 until the next transfer.
        en = 1'b0;
        cyc();
        en = 1'b1;
        cyc();
        check("direct_reenable_out", out, '0);
        check("direct_reenable_valid", out_valid, 1'b0);
        xfer(4'd7, 10'b0010000000, 1'b0);
        idle_hold(10'b0010000000);

        cyc(2);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
